div_unit: RTL and testbench

//   Multi-cycle sequential divider that executes the MIPS DIV instruction.

---
 rtl/div_unit.sv | 204 ++++++++++++++++++++
 tb/tb_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for the MIPS DIV instruction.
// LO receives the quotient and HI the remainder (truncating signed division).
// Optional build macro DIV_UNSIGNED_EN adds the div_unsigned input (DIVU).
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Iteration datapath
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [RW-1:0]    r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_rem_nx;
  logic [RW-1:0]    w_dvs_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_neg_q_nx;
  logic             w_neg_r_nx;

  // Registered outputs
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_busy_nx;
  logic             w_done_nx;
  logic             w_dz_nx;
  logic [WIDTH-1:0] w_lo_nx;
  logic [WIDTH-1:0] w_hi_nx;

  // Operand conditioning and trial subtraction
  logic             w_signed;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic             w_zero_dvs;
  logic [WIDTH-1:0] w_mag_a;
  logic [RW-1:0]    w_mag_b;
  logic [RW-1:0]    w_shift;
  logic             w_fit;

`ifdef DIV_UNSIGNED_EN
  assign w_signed = ~div_unsigned;
`else
  assign w_signed = 1'b1;
`endif

  assign w_sgn_a    = w_signed & dividend[WIDTH-1];
  assign w_sgn_b    = w_signed & divisor[WIDTH-1];
  assign w_zero_dvs = (divisor == '0);

  // Dividend magnitude: two's complement negation is exact when read as unsigned,
  // so the most negative value maps to 2^(WIDTH-1) without overflow.
  assign w_mag_a = w_sgn_a ? (~dividend + WIDTH'(1)) : dividend;
  // Divisor magnitude formed in WIDTH+1 bits from the sign-extended operand.
  assign w_mag_b = w_sgn_b ? (~{divisor[WIDTH-1], divisor} + RW'(1)) : {1'b0, divisor};

  // Shift the next dividend bit into the partial remainder and test against divisor.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_fit   = (w_shift >= r_dvs);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = w_zero_dvs ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_state_nx = S_FIX;
        end
      end
      S_FIX:   w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    w_quo_nx   = r_quo;
    w_rem_nx   = r_rem;
    w_dvs_nx   = r_dvs;
    w_cnt_nx   = r_cnt;
    w_neg_q_nx = r_neg_q;
    w_neg_r_nx = r_neg_r;
    w_dz_nx    = r_dz;
    w_lo_nx    = r_lo;
    w_hi_nx    = r_hi;
    w_busy_nx  = (w_state_nx != S_IDLE);
    w_done_nx  = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_neg_q_nx = w_sgn_a ^ w_sgn_b;
          w_neg_r_nx = w_sgn_a;
          if (w_zero_dvs) begin
            w_dz_nx = 1'b1;
            w_lo_nx = '0;
            w_hi_nx = '0;
          end else begin
            w_quo_nx = w_mag_a;
            w_rem_nx = '0;
            w_dvs_nx = w_mag_b;
            w_cnt_nx = CW'(WIDTH - 1);
          end
        end
      end
      S_RUN: begin
        w_quo_nx = {r_quo[WIDTH-2:0], w_fit};
        w_rem_nx = w_fit ? WIDTH'(w_shift - r_dvs) : w_shift[WIDTH-1:0];
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      S_FIX: begin
        w_lo_nx = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
        w_hi_nx = r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
        w_dz_nx = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_quo   <= w_quo_nx;
      r_rem   <= w_rem_nx;
      r_dvs   <= w_dvs_nx;
      r_cnt   <= w_cnt_nx;
      r_neg_q <= w_neg_q_nx;
      r_neg_r <= w_neg_r_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_dz    <= w_dz_nx;
      r_lo    <= w_lo_nx;
      r_hi    <= w_hi_nx;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign lo_out   = r_lo;
  assign hi_out   = r_hi;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized divisions checked against an arithmetic model.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef DIV_UNSIGNED_EN
  logic         div_unsigned;
`endif
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] lo_out;
  logic [W-1:0] hi_out;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_UNSIGNED_EN
    .div_unsigned(div_unsigned),
`endif
    .busy        (busy),
    .done        (done),
    .div_zero    (div_zero),
    .lo_out      (lo_out),
    .hi_out      (hi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division with plain 64-bit arithmetic.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                       output logic [W-1:0] lo, output logic [W-1:0] hi, output bit dz);
    longint sa;
    longint sb;
    dz = (b == '0);
    lo = '0;
    hi = '0;
    if (!dz) begin
      if (uns) begin
        lo = a / b;
        hi = a % b;
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lo = W'(sa / sb);
        hi = W'(sa % sb);
      end
    end
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns, input bit inject);
    logic [W-1:0] e_lo;
    logic [W-1:0] e_hi;
    bit           e_dz;
    int           k;
    int           busy_cyc;
    int           exp_k;
    string        id;
    model(a, b, uns, e_lo, e_hi, e_dz);
    exp_k = e_dz ? 1 : int'(W) + 2;
    id = $sformatf("%h/%h u%0d", a, b, uns);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV_UNSIGNED_EN
    div_unsigned = uns;
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
    k        = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && k < int'(W) + 8) begin
      if (inject && k == 5) begin
        start    = 1'b1;
        dividend = ~a;
        divisor  = 32'd3;
      end
      @(posedge clk);
      #1;
      k++;
      start = 1'b0;
      if (!done && busy) busy_cyc++;
    end
    check({"latency ", id}, 64'(k), 64'(exp_k));
    check({"busy_cycles ", id}, 64'(busy_cyc), 64'(exp_k));
    check({"lo ", id}, 64'(lo_out), 64'(e_lo));
    check({"hi ", id}, 64'(hi_out), 64'(e_hi));
    check({"div_zero ", id}, 64'(div_zero), 64'(e_dz));
    @(posedge clk);
    #1;
    check({"done_pulse ", id}, 64'(done), 64'd0);
    check({"lo_hold ", id}, 64'(lo_out), 64'(e_lo));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = W'($urandom_range(1, 40));
      6:       v = -W'($urandom_range(1, 40));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_UNSIGNED_EN
    div_unsigned = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div(32'd7, 32'd2, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

    // Abort a division mid-RUN with reset; outputs must clear at once.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done_after", 64'(done), 64'd0);
    run_div(32'd100, 32'd7, 1'b0, 1'b0);

`ifdef DIV_UNSIGNED_EN
    run_div(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32'd9, 32'd0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           u;
      a = pick();
      b = pick();
      u = 1'b0;
`ifdef DIV_UNSIGNED_EN
      u = ($urandom_range(0, 1) == 1);
`endif
      run_div(a, b, u, (i % 7) == 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
